// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time RAM loader: loader FSM states and
// the basic byte/RAM sizing constants used by the loader and its bench.
package cpu_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_RAM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Boot-time loader in front of the 256x16 RAM. It takes a byte stream
// (count, high/low byte pairs, XOR checksum) over a valid/ready handshake,
// writes the assembled words from address 0 upward and flags a checksum
// mismatch. Outside a load the CPU's RAM port passes straight through.
module ram_loader
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = DEFAULT_RAM_DEPTH
) (
  input  logic                  CPUclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]      cpu_wdata,
  input  logic                  cpu_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // One extra bit so that a full-depth load (count byte 0) is representable.
  localparam int REM_W = ADDR_WIDTH + 1;

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REM_W-1:0]      remaining_q, remaining_d;
  logic [BYTE_W-1:0]     acc_q, acc_d;
  logic [BYTE_W-1:0]     hi_q, hi_d;
  logic [BYTE_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic readyState;
  logic xfer;

  // Ready is purely a function of state (and held low during reset).
  always_comb begin
    readyState = (state_q == COUNT) || (state_q == HI) ||
                 (state_q == LO)    || (state_q == CHECK);
    byte_ready = readyState && !reset;
    xfer       = byte_valid && byte_ready;
  end

  // Next-state logic: stream parsing, word assembly, address/count tracking.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = done_q;
    error_d     = error_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COUNT;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      COUNT: begin
        if (xfer) begin
          remaining_d = (byte_in == '0) ? REM_W'(DEPTH) : REM_W'(byte_in);
          state_d     = HI;
        end
      end
      HI: begin
        if (xfer) begin
          hi_d    = byte_in;
          acc_d   = acc_q ^ byte_in;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer) begin
          lo_d    = byte_in;
          acc_d   = acc_q ^ byte_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - REM_W'(1);
        state_d     = (remaining_q == REM_W'(1)) ? CHECK : HI;
      end
      CHECK: begin
        if (xfer) begin
          error_d = (byte_in != acc_q);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CPUclk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // RAM port mux: CPU passthrough when idle/done, loader ownership otherwise;
  // no write of any kind may reach the RAM while reset is held.
  always_comb begin
    busy = !((state_q == IDLE) || (state_q == DONE));
    if (busy) begin
      ram_addr  = addr_q;
      ram_wdata = {hi_q, lo_q};
      ram_we    = (state_q == WRITE);
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end
    if (reset) begin
      ram_we = 1'b0;
    end
    done  = done_q;
    error = error_q;
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: builds byte streams and the write
// sequence they should produce, then drives them with random gaps and CPU
// noise and compares every RAM write and the final status flags.
module tb_ram_loader;

  logic        CPUclk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        busy;
  logic        done;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  streamQ[$];
  logic [7:0]  expAddrQ[$];
  logic [15:0] expDataQ[$];
  logic [7:0]  expChk;
  logic        expErr;
  int          expWrites;

  ram_loader dut (
    .CPUclk(CPUclk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .done(done), .error(error)
  );

  // Free-running clock.
  always #5 CPUclk = ~CPUclk;

  // Single comparison point: counts every vector and every miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Start a new reference load: count byte first, fresh expectations.
  task automatic beginLoad(input int nWords);
    streamQ.delete();
    expAddrQ.delete();
    expDataQ.delete();
    expChk    = 8'h00;
    expWrites = 0;
    streamQ.push_back(nWords[7:0]);
  endtask

  // Append one word: high byte then low byte, to be written at the next address.
  task automatic pushWord(input logic [7:0] hi, input logic [7:0] lo);
    streamQ.push_back(hi);
    streamQ.push_back(lo);
    expChk = expChk ^ hi ^ lo;
    expAddrQ.push_back(expWrites[7:0]);
    expDataQ.push_back({hi, lo});
    expWrites++;
  endtask

  // Close the stream with the checksum, optionally corrupted.
  task automatic finishLoad(input bit corrupt);
    streamQ.push_back(corrupt ? (expChk ^ 8'h01) : expChk);
    expErr = corrupt;
  endtask

  // Random load of nWords words.
  task automatic buildRandom(input int nWords, input bit corrupt);
    beginLoad(nWords);
    for (int i = 0; i < nWords; i++) pushWord(8'($urandom), 8'($urandom));
    finishLoad(corrupt);
  endtask

  // Run the prepared stream. Returns early after stopAfter writes if nonzero.
  task automatic applyStimulus(input int gapPct, input bit cpuNoise,
                               input bit startInHi, input int stopAfter,
                               input int maxCycles);
    int  cyc    = 0;
    int  writes = 0;
    int  xfers  = 0;
    bit  halted = 0;
    @(negedge CPUclk);
    start = 1'b1;
    @(negedge CPUclk);
    start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("doneClearedOnStart", done, 0);
    while (!done && !halted && cyc < maxCycles) begin
      if (ram_we) begin
        writes++;
        if (expAddrQ.size() == 0) begin
          checkOutput("writeCount", writes, expWrites);
        end else begin
          checkOutput("wrAddr", ram_addr, expAddrQ.pop_front());
          checkOutput("wrData", ram_wdata, expDataQ.pop_front());
        end
      end
      if (stopAfter != 0 && writes == stopAfter) begin
        halted = 1;
      end else begin
        start     = startInHi && (xfers == 3) && byte_ready;
        cpu_we    = cpuNoise;
        cpu_addr  = 8'($urandom);
        cpu_wdata = 16'($urandom);
        if (streamQ.size() > 0 && $urandom_range(99) >= gapPct) begin
          byte_valid = 1'b1;
          byte_in    = streamQ[0];
          if (byte_ready) begin
            void'(streamQ.pop_front());
            xfers++;
          end
        end else begin
          byte_valid = 1'b0;
          byte_in    = 8'($urandom);
        end
        @(negedge CPUclk);
        cyc++;
      end
    end
    start  = 1'b0;
    cpu_we = 1'b0;
    if (!halted) begin
      byte_valid = 1'b0;
      checkOutput("noTimeout", 32'(cyc < maxCycles), 1);
      checkOutput("writeCount", writes, expWrites);
      checkOutput("streamConsumed", streamQ.size(), 0);
      checkOutput("done", done, 1);
      checkOutput("error", error, expErr);
      checkOutput("busyAfterDone", busy, 0);
      checkOutput("readyAfterDone", byte_ready, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b1;
    cpu_addr   = 8'h33;
    cpu_wdata  = 16'hBEEF;
    cpu_we     = 1'b1;

    // Reset state, with CPU write and byte_valid active to prove gating.
    repeat (3) @(negedge CPUclk);
    checkOutput("rstRamWe", ram_we, 0);
    checkOutput("rstReady", byte_ready, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstError", error, 0);
    reset      = 1'b0;
    byte_valid = 1'b0;
    @(negedge CPUclk);
    checkOutput("idlePassAddr", ram_addr, 8'h33);
    checkOutput("idlePassData", ram_wdata, 16'hBEEF);
    checkOutput("idlePassWe", ram_we, 1);
    cpu_we = 1'b0;

    // Directed load, byte_valid held high, good checksum 0x40.
    beginLoad(2);
    pushWord(8'h12, 8'h34);
    pushWord(8'hAB, 8'hCD);
    finishLoad(0);
    checkOutput("chkModel", expChk, 8'h40);
    applyStimulus(0, 0, 0, 0, 100);

    // Same load with checksum 0x41.
    beginLoad(2);
    pushWord(8'h12, 8'h34);
    pushWord(8'hAB, 8'hCD);
    finishLoad(1);
    applyStimulus(0, 0, 0, 0, 100);

    // Full-depth load: count 0, 512 incrementing bytes.
    beginLoad(256);
    for (int i = 0; i < 256; i++) pushWord(8'(2 * i), 8'(2 * i + 1));
    finishLoad(0);
    applyStimulus(0, 0, 0, 0, 2000);

    // Gappy stream with CPU writes attempted throughout, then passthrough.
    buildRandom(7, 0);
    applyStimulus(35, 1, 0, 0, 500);
    cpu_addr  = 8'h10;
    cpu_wdata = 16'h5555;
    cpu_we    = 1'b1;
    #1;
    checkOutput("donePassAddr", ram_addr, 8'h10);
    checkOutput("donePassData", ram_wdata, 16'h5555);
    checkOutput("donePassWe", ram_we, 1);
    cpu_we = 1'b0;

    // start pulsed while in HI must be ignored.
    buildRandom(5, 0);
    applyStimulus(20, 0, 1, 0, 300);

    // A few random loads with random gaps and random checksum corruption.
    for (int k = 0; k < 3; k++) begin
      buildRandom($urandom_range(1, 20), 1'($urandom_range(1)));
      applyStimulus($urandom_range(40), 1'($urandom_range(1)), 0, 0, 500);
    end

    // Reset right after the first word write, then a fresh count=1 load.
    buildRandom(3, 0);
    applyStimulus(0, 0, 0, 1, 100);
    reset      = 1'b1;
    byte_valid = 1'b1;
    cpu_we     = 1'b1;
    #1;
    checkOutput("midRstRamWe", ram_we, 0);
    checkOutput("midRstReady", byte_ready, 0);
    @(negedge CPUclk);
    reset      = 1'b0;
    byte_valid = 1'b0;
    cpu_we     = 1'b0;
    #1;
    checkOutput("postRstBusy", busy, 0);
    checkOutput("postRstDone", done, 0);
    checkOutput("postRstRamWe", ram_we, 0);
    beginLoad(1);
    pushWord(8'h00, 8'h07);
    finishLoad(0);
    checkOutput("chkModel2", expChk, 8'h07);
    applyStimulus(10, 0, 0, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time loader sitting directly upstream of the 256x16 data/program RAM.
- Consumes a byte stream from the serial receiver through a valid/ready handshake and assembles 16-bit words from it.
- Writes the words sequentially into the RAM from address 0, then verifies an XOR checksum.
- Owns the RAM write/address port while loading and holds the CPU off. When idle or done it passes the CPU's RAM port through unchanged.

Parameters:
- WIDTH, 16, RAM data width; must be 16 (two bytes per word).
- ADDR_WIDTH, 8, RAM address width.
- DEPTH, 256, maximum words per load; equals 2**ADDR_WIDTH.

Ports:
- CPUclk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when idle or done.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- cpu_addr  in  ADDR_WIDTH  CPU RAM address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_we  in  1  CPU write enable.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  WIDTH  to RAM wdata.
- ram_we  out  1  to RAM we.
- busy  out  1  loader owns the RAM; CPU must stall.
- done  out  1  load finished; held until the next start or reset.
- error  out  1  checksum mismatch on the last load; valid when done=1.

Behaviour:
- Handshake:
  - A byte transfers in a cycle where byte_valid and byte_ready are both 1.
  - byte_ready depends only on state, never combinationally on byte_valid.
- Stream format, in order:
  - one count byte N; N=0 means 256 words;
  - N words, each high byte first;
  - one checksum byte = XOR of all 2N data bytes (count byte excluded).
- FSM states: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE.
  - IDLE/DONE:
    - byte_ready=0, busy=0.
    - ram_addr/ram_wdata/ram_we = cpu_addr/cpu_wdata/cpu_we (combinational passthrough).
    - start -> COUNT; this clears done, error, the word address (to 0) and the checksum accumulator.
  - COUNT: byte_ready=1, busy=1. On transfer, latch remaining = (byte==0 ? 256 : byte) as a 9-bit value -> HI.
  - HI: byte_ready=1. On transfer, latch the high byte and XOR it into the accumulator -> LO.
  - LO: byte_ready=1. On transfer, latch the low byte and XOR it into the accumulator -> WRITE.
  - WRITE (exactly one cycle):
    - byte_ready=0; ram_we=1; ram_addr = address register; ram_wdata = {hi,lo}.
    - Increment address, decrement remaining.
    - -> CHECK if remaining becomes 0, else -> HI.
  - CHECK: byte_ready=1. On transfer, error <= (byte != accumulator), done <= 1 -> DONE.
- While busy:
  - cpu_we is ignored and never reaches ram_we.
  - ram_we=0 in every state except WRITE.
  - ram_addr shows the address register.
- Latency:
  - Each word is written one cycle after its low byte transfers.
  - done and error are registered 1 the cycle after the checksum byte transfers.
- Boundaries:
  - N=0 loads 256 words, addresses 0..255; the 8-bit address wraps to 0 after the last write, with no extra write.
  - start while busy is ignored.
  - byte_valid while byte_ready=0 (IDLE/DONE/WRITE) is not consumed; the source holds the byte.
  - byte_valid may stay high across back-to-back bytes; one transfer per cycle.
- Reset, including mid-load, on the next edge:
  - state=IDLE; done=0, error=0; address=0, accumulator=0, remaining=0.
  - Words already written stay in RAM.
  - While reset is high, ram_we is forced to 0 and byte_ready=0.

Decomposition:
- Shared package (cpu_pkg):
  - loader_state_t enum for the seven states;
  - constants BYTE_W=8 and DEFAULT_RAM_DEPTH=256.
- No sub-module. The port mux is a small combinational block inside this module.

Test Plan:
- Load count=2, bytes 12 34 AB CD, checksum 40, byte_valid held high:
  - ram_we pulses twice: addr 0 data 0x1234, addr 1 data 0xABCD;
  - done=1, error=0; busy=0 afterwards.
- Same load with checksum 41:
  - both words written; done=1, error=1.
- Count=0, 512 incrementing data bytes, correct checksum:
  - 256 writes, addr 0..255; last write addr 255;
  - no write to addr 0 after wrap; done=1, error=0.
- Gaps in byte_valid plus cpu_we=1 asserted throughout the load:
  - RAM sees only loader writes;
  - after DONE, cpu_we=1 at cpu_addr 0x10 with data 0x5555 passes straight to ram_*.
- Reset asserted after the first word is written, then start with a new count=1 load 00 07 checksum 07:
  - after reset, busy=0, done=0, ram_we=0;
  - new load writes 0x0007 to addr 0, error=0.
- start pulsed during HI:
  - ignored; load completes normally at the correct addresses.
